// File: rtl/sram_like_responder_pkg.sv
// Shared constants for the sram-like bus responder: transfer sizes and the
// stall LFSR polynomial (x^16 + x^14 + x^13 + x^11 + 1, right-shifting form).
package sram_like_responder_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Tap mask over the register bits that feed back into bit 15.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/sram_like_responder_resp_delay_line.sv
// Fixed-latency response line: stage 0 holds {valid, is_wr} of the accepted
// request, the RAM word joins the cycle after, then LAT-1 more data stages.
module sram_like_responder_resp_delay_line #(
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        in_vld,
    input  logic        in_wr,
    input  logic [31:0] ram_rdata,
    output logic        out_vld,
    output logic [31:0] out_data
);

    logic [LAT:0] vld_q, vld_d;
    logic         wr0_q, wr0_d;
    logic [31:0]  stage0_data;

    always_comb begin
        vld_d    = '0;
        vld_d[0] = in_vld;
        for (int k = 1; k <= LAT; k++) vld_d[k] = vld_q[k-1];
        wr0_d = in_vld & in_wr;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            vld_q <= '0;
            wr0_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
            wr0_q <= wr0_d;
        end
    end

    // Data is zeroed at entry, so every later stage is zero when invalid or a write.
    assign stage0_data = (vld_q[0] & ~wr0_q) ? ram_rdata : 32'h0;
    assign out_vld     = vld_q[LAT];

    generate
        if (LAT == 0) begin : g_lat0
            assign out_data = stage0_data;
        end else begin : g_latn
            logic [LAT:1][31:0] data_q, data_d;

            always_comb begin
                data_d    = data_q;
                data_d[1] = stage0_data;
                for (int k = 2; k <= LAT; k++) data_d[k] = data_q[k-1];
            end

            always_ff @(posedge clk) begin
                if (clr) data_q <= '0;
                else     data_q <= data_d;
            end

            assign out_data = data_q[LAT];
        end
    endgenerate

endmodule

// File: rtl/sram_like_responder.sv
// Responder end of the sram-like bus: drives a synchronous word RAM and
// returns in-order responses after a fixed latency, with optional stalls.
module sram_like_responder
    import sram_like_responder_pkg::*;
#(
    parameter int          MEM_AW     = 16,
    parameter int          LAT        = 2,
    parameter int          MAX_OUTST  = 2,
    parameter int          RAND_STALL = 0,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic [3:0]        wen,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              addr_ok,
    output logic              data_ok,
    output logic [31:0]       rdata,
    output logic              ram_en,
    output logic [3:0]        ram_wen,
    output logic [MEM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam int CW = 4;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic          stall_ok, hs;
    logic          dl_vld;
    logic [31:0]   dl_data;
    logic          unused_bits;

    assign unused_bits = ^{size, addr[31:MEM_AW+2], addr[1:0]};

    // The slot count is the registered value: a response this cycle does not free a slot.
    assign stall_ok = (RAND_STALL != 0) ? lfsr_q[0] : 1'b1;
    assign addr_ok  = en & ~reset & (cnt_q < CW'(MAX_OUTST)) & stall_ok;
    assign hs       = en & addr_ok;

    assign ram_en    = hs;
    assign ram_wen   = (hs & wr) ? wen : 4'h0;
    assign ram_addr  = addr[MEM_AW+1:2];
    assign ram_wdata = wdata;

    sram_like_responder_resp_delay_line #(.LAT(LAT)) u_dly (
        .clk      (clk),
        .clr      (reset),
        .in_vld   (hs),
        .in_wr    (wr),
        .ram_rdata(ram_rdata),
        .out_vld  (dl_vld),
        .out_data (dl_data)
    );

    // Mask the line while reset is held so pre-reset requests never answer.
    assign data_ok = dl_vld & ~reset;
    assign rdata   = reset ? 32'h0 : dl_data;

    always_comb begin
        cnt_d = cnt_q;
        case ({hs, data_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        lfsr_d = (RAND_STALL != 0) ? lfsr_next(lfsr_q) : lfsr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            lfsr_q <= LFSR_SEED;
        end else begin
            cnt_q  <= cnt_d;
            lfsr_q <= lfsr_d;
            assert (!(data_ok && !hs && cnt_q == '0));
            assert (!(hs && !data_ok && cnt_q == CW'(MAX_OUTST)));
        end
    end

endmodule

// File: tb/tb_sram_like_responder.sv
// Directed bench: three responder configurations, each with a behavioural RAM.
module tb_sram_like_responder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // A: LAT=2, MAX_OUTST=2; B: LAT=0, MAX_OUTST=8; C: LAT=1, MAX_OUTST=3, random stalls
    logic        a_en, a_wr, a_addr_ok, a_data_ok, a_ram_en;
    logic [1:0]  a_size;
    logic [3:0]  a_wen, a_ram_wen;
    logic [31:0] a_addr, a_wdata, a_rdata, a_ram_wdata, a_ram_rdata;
    logic [7:0]  a_ram_addr;
    logic        b_en, b_wr, b_addr_ok, b_data_ok, b_ram_en;
    logic [1:0]  b_size;
    logic [3:0]  b_wen, b_ram_wen;
    logic [31:0] b_addr, b_wdata, b_rdata, b_ram_wdata, b_ram_rdata;
    logic [7:0]  b_ram_addr;
    logic        c_en, c_wr, c_addr_ok, c_data_ok, c_ram_en;
    logic [1:0]  c_size;
    logic [3:0]  c_wen, c_ram_wen;
    logic [31:0] c_addr, c_wdata, c_rdata, c_ram_wdata, c_ram_rdata;
    logic [7:0]  c_ram_addr;

    logic [31:0] mem_a [0:255];
    logic [31:0] mem_b [0:255];
    logic [31:0] mem_c [0:255];

    int checks = 0;
    int errors = 0;

    sram_like_responder #(.MEM_AW(8), .LAT(2), .MAX_OUTST(2), .RAND_STALL(0)) dut_a (
        .clk(clk), .reset(reset), .en(a_en), .wr(a_wr), .size(a_size), .wen(a_wen),
        .addr(a_addr), .wdata(a_wdata), .addr_ok(a_addr_ok), .data_ok(a_data_ok),
        .rdata(a_rdata), .ram_en(a_ram_en), .ram_wen(a_ram_wen), .ram_addr(a_ram_addr),
        .ram_wdata(a_ram_wdata), .ram_rdata(a_ram_rdata));

    sram_like_responder #(.MEM_AW(8), .LAT(0), .MAX_OUTST(8), .RAND_STALL(0)) dut_b (
        .clk(clk), .reset(reset), .en(b_en), .wr(b_wr), .size(b_size), .wen(b_wen),
        .addr(b_addr), .wdata(b_wdata), .addr_ok(b_addr_ok), .data_ok(b_data_ok),
        .rdata(b_rdata), .ram_en(b_ram_en), .ram_wen(b_ram_wen), .ram_addr(b_ram_addr),
        .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata));

    sram_like_responder #(.MEM_AW(8), .LAT(1), .MAX_OUTST(3), .RAND_STALL(1),
                          .LFSR_SEED(16'hACE1)) dut_c (
        .clk(clk), .reset(reset), .en(c_en), .wr(c_wr), .size(c_size), .wen(c_wen),
        .addr(c_addr), .wdata(c_wdata), .addr_ok(c_addr_ok), .data_ok(c_data_ok),
        .rdata(c_rdata), .ram_en(c_ram_en), .ram_wen(c_ram_wen), .ram_addr(c_ram_addr),
        .ram_wdata(c_ram_wdata), .ram_rdata(c_ram_rdata));

    function automatic logic [31:0] init_word(input int i);
        logic [7:0] b;
        b = i[7:0];
        if (i == 16) return 32'hDEADBEEF;
        if (i == 2)  return 32'hAAAAAAAA;
        return {8'hC3, b, ~b, b ^ 8'h5A};
    endfunction

    // Behavioural RAMs, reloaded while reset is held.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) begin
                mem_a[i] <= init_word(i);
                mem_b[i] <= init_word(i);
                mem_c[i] <= init_word(i);
            end
        end else begin
            if (a_ram_en) begin
                for (int j = 0; j < 4; j++)
                    if (a_ram_wen[j]) mem_a[a_ram_addr][8*j +: 8] <= a_ram_wdata[8*j +: 8];
                a_ram_rdata <= mem_a[a_ram_addr];
            end
            if (b_ram_en) begin
                for (int j = 0; j < 4; j++)
                    if (b_ram_wen[j]) mem_b[b_ram_addr][8*j +: 8] <= b_ram_wdata[8*j +: 8];
                b_ram_rdata <= mem_b[b_ram_addr];
            end
            if (c_ram_en) begin
                for (int j = 0; j < 4; j++)
                    if (c_ram_wen[j]) mem_c[c_ram_addr][8*j +: 8] <= c_ram_wdata[8*j +: 8];
                c_ram_rdata <= mem_c[c_ram_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_req(input logic e, input logic w, input logic [31:0] ad,
                         input logic [3:0] we, input logic [31:0] wd);
        a_en = e; a_wr = w; a_addr = ad; a_wen = we; a_wdata = wd;
    endtask

    // Random-phase model state
    logic [15:0] ml;
    logic [1:0]  mv;
    int          mcnt, hs_cnt, cyc, gaps, w;
    logic        eok;
    logic [31:0] expd;
    logic [31:0] q [$];

    initial begin
        reset = 1'b1;
        a_req(0, 0, 0, 0, 0); a_size = 2'd2;
        b_en = 0; b_wr = 0; b_size = 2'd2; b_wen = 0; b_addr = 0; b_wdata = 0;
        c_en = 0; c_wr = 0; c_size = 2'd2; c_wen = 0; c_addr = 0; c_wdata = 0;
        tick(); tick();

        // Reset state, with a request pending on A
        a_req(1, 1, 32'h40, 4'hF, 32'h1);
        #1;
        chk("rst_addr_ok", a_addr_ok, 0);
        chk("rst_data_ok", a_data_ok, 0);
        chk("rst_rdata", a_rdata, 0);
        chk("rst_ram_en", a_ram_en, 0);
        chk("rst_ram_wen", a_ram_wen, 0);
        tick();
        reset = 1'b0;
        a_req(0, 0, 0, 0, 0);
        tick();

        // Single read, response 3 cycles after the handshake
        a_req(1, 0, 32'h40, 4'h0, 0);
        #1;
        chk("rd_addr_ok", a_addr_ok, 1);
        chk("rd_ram_en", a_ram_en, 1);
        chk("rd_ram_addr", a_ram_addr, 8'h10);
        chk("rd_ram_wen", a_ram_wen, 0);
        chk("rd_data_ok_c0", a_data_ok, 0);
        tick();
        a_req(0, 0, 0, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            #1;
            chk("rd_data_ok", a_data_ok, (k == 3));
            chk("rd_rdata", a_rdata, (k == 3) ? 32'hDEADBEEF : 32'h0);
            tick();
        end

        // Partial write then read of the same word
        a_req(1, 1, 32'h8, 4'b0011, 32'h12345678);
        #1;
        chk("wr_addr_ok", a_addr_ok, 1);
        chk("wr_ram_wen", a_ram_wen, 4'b0011);
        chk("wr_ram_wdata", a_ram_wdata, 32'h12345678);
        chk("wr_ram_addr", a_ram_addr, 8'h02);
        tick();
        a_req(1, 0, 32'h8, 4'hF, 32'h0);
        #1;
        chk("raw_addr_ok", a_addr_ok, 1);
        chk("raw_ram_wen", a_ram_wen, 0);
        tick();
        a_req(0, 0, 0, 0, 0);
        for (int k = 2; k <= 5; k++) begin
            #1;
            chk("raw_data_ok", a_data_ok, (k == 3 || k == 4));
            chk("raw_rdata", a_rdata, (k == 4) ? 32'hAAAA5678 : 32'h0);
            tick();
        end

        // Outstanding limit with en held: handshakes at 0,1,4,5; responses at 3,4,7,8
        for (int k = 0; k <= 9; k++) begin
            a_req(k <= 6, 0, 32'h40, 0, 0);
            #1;
            chk("lim_addr_ok", a_addr_ok, (k == 0 || k == 1 || k == 4 || k == 5));
            chk("lim_data_ok", a_data_ok, (k == 3 || k == 4 || k == 7 || k == 8));
            if (k == 3 || k == 8) chk("lim_rdata", a_rdata, 32'hDEADBEEF);
            tick();
        end
        a_req(0, 0, 0, 0, 0);

        // Reset one cycle after two reads were accepted
        a_req(1, 0, 32'h40, 0, 0);
        #1; chk("mid_hs0", a_addr_ok, 1); tick();
        #1; chk("mid_hs1", a_addr_ok, 1); tick();
        reset = 1'b1;
        #1; chk("mid_rst_addr_ok", a_addr_ok, 0); tick();
        reset = 1'b0;
        a_req(0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            #1; chk("mid_no_data_ok", a_data_ok, 0); tick();
        end
        // Two fresh reads both accepted, a third refused: count restarted at 0
        for (int k = 0; k <= 5; k++) begin
            a_req(k <= 2, 0, 32'h40, 0, 0);
            #1;
            chk("post_addr_ok", a_addr_ok, (k <= 1));
            chk("post_data_ok", a_data_ok, (k == 3 || k == 4));
            if (k == 3) chk("post_rdata", a_rdata, 32'hDEADBEEF);
            tick();
        end
        a_req(0, 0, 0, 0, 0);

        // B: 8 back-to-back reads with LAT=0
        for (int k = 0; k <= 9; k++) begin
            b_en = (k < 8);
            b_addr = (32'h20 + k) << 2;
            #1;
            chk("b2b_addr_ok", b_addr_ok, (k < 8));
            chk("b2b_data_ok", b_data_ok, (k >= 1 && k <= 8));
            chk("b2b_rdata", b_rdata, (k >= 1 && k <= 8) ? init_word(32'h20 + k - 1) : 32'h0);
            tick();
        end
        b_en = 0;

        // C: random reads against an LFSR/count model, starting from a fresh reset
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        ml = 16'hACE1; mv = 2'b00; mcnt = 0; hs_cnt = 0; cyc = 0; gaps = 0;
        while (hs_cnt < 1000 && cyc < 20000) begin
            c_en = ($urandom_range(0, 3) != 0);
            w = int'($urandom_range(0, 255));
            c_addr = w << 2;
            #1;
            eok = c_en && (mcnt < 3) && ml[0];
            chk("rnd_addr_ok", c_addr_ok, eok);
            chk("rnd_data_ok", c_data_ok, mv[1]);
            if (c_data_ok) begin
                chk("rnd_q_nonempty", (q.size() != 0), 1);
                if (q.size() != 0) begin
                    expd = q.pop_front();
                    chk("rnd_rdata", c_rdata, expd);
                end
            end
            if (c_en && !c_addr_ok) gaps++;
            if (c_en && c_addr_ok) begin
                q.push_back(init_word(w));
                hs_cnt++;
            end
            mcnt = mcnt + int'(eok) - int'(mv[1]);
            mv = {mv[0], eok};
            ml = {ml[0] ^ ml[2] ^ ml[3] ^ ml[5], ml[15:1]};
            tick();
            cyc++;
        end
        c_en = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("drain_data_ok", c_data_ok, mv[1]);
            if (c_data_ok && q.size() != 0) begin
                expd = q.pop_front();
                chk("drain_rdata", c_rdata, expd);
            end
            mv = {mv[0], 1'b0};
            tick();
        end
        chk("rnd_handshakes", hs_cnt, 1000);
        chk("rnd_all_answered", q.size(), 0);
        chk("rnd_gaps_seen", (gaps > 0), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
